// File: rtl/lif_group_sequencer_pkg.sv
// lif_pkg: shared constants and FSM state encoding for the LIF group sequencer.
//   NEURONS_PER_GROUP : lanes processed together per memory word
//   POT_W             : unsigned membrane potential / current / threshold width
//   BETA_W            : per-lane decay coefficient width
package lif_pkg;

    localparam int NEURONS_PER_GROUP = 16;
    localparam int POT_W             = 8;
    localparam int BETA_W            = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_DECAY = 3'd3;
    localparam logic [2:0] ST_FIRE  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RD    = ST_RD,
        S_LOAD  = ST_LOAD,
        S_DECAY = ST_DECAY,
        S_FIRE  = ST_FIRE,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/lif_group_sequencer_if.sv
// lif_group_sequencer_if: all non-clock/reset signals of the sequencer.
//   control  : start, busy, done, beta_cfg, thr_cfg
//   memory   : mem_rd_en, mem_wr_en, mem_addr, mem_rd_data, mem_wr_data
//   current  : cur_16n_in, cur_valid, cur_ready
//   u_b_proc : load_16n_* and save_16n_* load/save paths
//   spikes   : spk_out, spk_valid, spk_group
// modport master = sequencer side, slave = surrounding logic side.
interface lif_group_sequencer_if #(
    parameter int ADDR_W = 3
);
    import lif_pkg::*;

    localparam int VEC_W  = NEURONS_PER_GROUP * POT_W;
    localparam int BVEC_W = NEURONS_PER_GROUP * BETA_W;

    logic                         start;
    logic                         busy;
    logic                         done;
    logic [BVEC_W-1:0]            beta_cfg;
    logic [POT_W-1:0]             thr_cfg;
    logic                         mem_rd_en;
    logic                         mem_wr_en;
    logic [ADDR_W-1:0]            mem_addr;
    logic [VEC_W-1:0]             mem_rd_data;
    logic [VEC_W-1:0]             mem_wr_data;
    logic [VEC_W-1:0]             cur_16n_in;
    logic                         cur_valid;
    logic                         cur_ready;
    logic [VEC_W-1:0]             load_16n_potential_in;
    logic [BVEC_W-1:0]            load_16n_beta_in;
    logic [VEC_W-1:0]             load_16n_potential_out;
    logic [VEC_W-1:0]             save_16n_potential_in;
    logic [NEURONS_PER_GROUP-1:0] save_16n_spk_in;
    logic [VEC_W-1:0]             save_16n_potential_out;
    logic [NEURONS_PER_GROUP-1:0] spk_out;
    logic                         spk_valid;
    logic [ADDR_W-1:0]            spk_group;

    modport master (
        input  start, beta_cfg, thr_cfg, mem_rd_data, cur_16n_in, cur_valid,
               load_16n_potential_out, save_16n_potential_out,
        output busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, cur_ready,
               load_16n_potential_in, load_16n_beta_in, save_16n_potential_in,
               save_16n_spk_in, spk_out, spk_valid, spk_group
    );

    modport slave (
        output start, beta_cfg, thr_cfg, mem_rd_data, cur_16n_in, cur_valid,
               load_16n_potential_out, save_16n_potential_out,
        input  busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, cur_ready,
               load_16n_potential_in, load_16n_beta_in, save_16n_potential_in,
               save_16n_spk_in, spk_out, spk_valid, spk_group
    );

endinterface

// File: rtl/lif_group_sequencer_sat_add_cmp.sv
// sat_add_cmp: one neuron lane.
//   dec_i   : decayed potential from the load path
//   cur_i   : synaptic current
//   sum_o   : min(255, dec_i + cur_i)
//   val_i   : registered sum to classify
//   thr_i   : spike threshold
//   spk_o   : val_i >= thr_i
module sat_add_cmp
    import lif_pkg::*;
(
    input  logic [POT_W-1:0] dec_i,
    input  logic [POT_W-1:0] cur_i,
    output logic [POT_W-1:0] sum_o,
    input  logic [POT_W-1:0] val_i,
    input  logic [POT_W-1:0] thr_i,
    output logic             spk_o
);

    function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0] a,
                                                 input logic [POT_W-1:0] b);
        logic [POT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[POT_W] ? {POT_W{1'b1}} : s[POT_W-1:0];
    endfunction

    assign sum_o = sat_add(dec_i, cur_i);
    assign spk_o = (val_i >= thr_i);

endmodule

// File: rtl/lif_group_sequencer.sv
// lif_group_sequencer: walks NUM_GROUPS 16-neuron groups per start.
// Per group: read potentials, decay through u_b_processor's load path, add
// synaptic current (saturating), threshold to spikes, spike-reset through the
// save path and write back; one spike vector is emitted per group.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lif_group_sequencer_if.master (control, memory, current
//                handshake, u_b_processor load/save paths, spike output)
module lif_group_sequencer
    import lif_pkg::*;
#(
    parameter  int NUM_GROUPS = 8,
    localparam int ADDR_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    lif_group_sequencer_if.master bus
);

    localparam int LANES  = NEURONS_PER_GROUP;
    localparam int VEC_W  = LANES * POT_W;
    localparam int BVEC_W = LANES * BETA_W;
    localparam logic [ADDR_W-1:0] LAST_G = ADDR_W'(NUM_GROUPS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   g_q, g_d;
    logic [VEC_W-1:0]    pot_q, pot_d;
    logic [VEC_W-1:0]    sum_q, sum_d;
    logic [BVEC_W-1:0]   beta_q, beta_d;
    logic [POT_W-1:0]    thr_q, thr_d;
    logic [LANES-1:0]    spk_hold_q, spk_hold_d;
    logic [ADDR_W-1:0]   grp_hold_q, grp_hold_d;

    logic [VEC_W-1:0]    sum_sat;
    logic [LANES-1:0]    spk;
    logic                rd_en, wr_en, cur_rdy, done_p, fire;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_add_cmp u_lane (
            .dec_i (bus.load_16n_potential_out[i*POT_W +: POT_W]),
            .cur_i (bus.cur_16n_in[i*POT_W +: POT_W]),
            .sum_o (sum_sat[i*POT_W +: POT_W]),
            .val_i (sum_q[i*POT_W +: POT_W]),
            .thr_i (thr_q),
            .spk_o (spk[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            pot_q      <= '0;
            sum_q      <= '0;
            beta_q     <= '0;
            thr_q      <= '0;
            spk_hold_q <= '0;
            grp_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            pot_q      <= pot_d;
            sum_q      <= sum_d;
            beta_q     <= beta_d;
            thr_q      <= thr_d;
            spk_hold_q <= spk_hold_d;
            grp_hold_q <= grp_hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        pot_d      = pot_q;
        sum_d      = sum_q;
        beta_d     = beta_q;
        thr_d      = thr_q;
        spk_hold_d = spk_hold_q;
        grp_hold_d = grp_hold_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        cur_rdy    = 1'b0;
        done_p     = 1'b0;
        fire       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Config is latched only here, so mid-frame edits wait for the next start.
                if (bus.start) begin
                    beta_d  = bus.beta_cfg;
                    thr_d   = bus.thr_cfg;
                    g_d     = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                rd_en   = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                pot_d   = bus.mem_rd_data;
                state_d = S_DECAY;
            end
            S_DECAY: begin
                cur_rdy = 1'b1;
                if (bus.cur_valid) begin
                    sum_d   = sum_sat;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                wr_en      = 1'b1;
                fire       = 1'b1;
                spk_hold_d = spk;
                grp_hold_d = g_q;
                if (g_q == LAST_G) begin
                    state_d = S_DONE;
                end else begin
                    g_d     = g_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                done_p  = 1'b1;
                g_d     = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy                  = (state_q != S_IDLE);
    assign bus.done                  = done_p;
    assign bus.mem_rd_en             = rd_en;
    assign bus.mem_wr_en             = wr_en;
    assign bus.mem_addr              = g_q;
    // Write data is gated so the bus stays quiet outside FIRE.
    assign bus.mem_wr_data           = fire ? bus.save_16n_potential_out : '0;
    assign bus.cur_ready             = cur_rdy;
    assign bus.load_16n_potential_in = pot_q;
    assign bus.load_16n_beta_in      = beta_q;
    assign bus.save_16n_potential_in = sum_q;
    assign bus.save_16n_spk_in       = spk;
    // Live value during FIRE so it lines up with spk_valid, held copy afterwards.
    assign bus.spk_out               = fire ? spk : spk_hold_q;
    assign bus.spk_valid             = fire;
    assign bus.spk_group             = fire ? g_q : grp_hold_q;

endmodule

// File: tb/tb_lif_group_sequencer.sv
module tb_lif_group_sequencer;
    import lif_pkg::*;

    localparam int NG = 2;
    localparam int AW = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lif_group_sequencer_if #(.ADDR_W(AW)) bus ();
    lif_group_sequencer #(.NUM_GROUPS(NG)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          mode;
        logic [7:0]  pre;
        logic [7:0]  cur;
        logic [7:0]  thr;
        logic [15:0] exp_spk;
        logic [127:0] exp_wr;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int stub_mode = 0;
    int rw_overlap = 0;
    logic [127:0] mem [NG];
    logic [127:0] rd_data, rd_pend;
    bit           rd_pend_v;

    int busy1, n_done, done_at, n_ev, strobe_bad;
    logic [15:0]   ev_spk [8];
    logic [AW-1:0] ev_grp [8];
    logic [63:0]   beta_seen;
    logic [15:0]   exp_spk [NG];
    logic [127:0]  exp_mem [NG];

    // u_b_processor stand-in: selectable decay law, spike reset to zero
    function automatic logic [7:0] stub_decay(input int mode, input logic [7:0] p,
                                              input int lane, input logic [3:0] b);
        case (mode)
            0:       return p >> 1;
            1:       return 8'd200;
            2:       return 8'(10 * lane);
            default: return p - (p >> b);
        endcase
    endfunction

    always_comb begin
        bus.load_16n_potential_out = '0;
        bus.save_16n_potential_out = '0;
        for (int i = 0; i < 16; i++) begin
            bus.load_16n_potential_out[8*i +: 8] =
                stub_decay(stub_mode, bus.load_16n_potential_in[8*i +: 8], i,
                           bus.load_16n_beta_in[4*i +: 4]);
            bus.save_16n_potential_out[8*i +: 8] =
                bus.save_16n_spk_in[i] ? 8'd0 : bus.save_16n_potential_in[8*i +: 8];
        end
    end

    assign bus.mem_rd_data = rd_data;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock; memory model serviced at the falling edge
    task automatic tick();
        @(negedge clk);
        rd_data   = rd_pend_v ? rd_pend : {4{32'hDEADBEEF}};
        rd_pend_v = 1'b0;
        if (bus.mem_rd_en && bus.mem_wr_en) rw_overlap++;
        if (bus.mem_rd_en) begin
            rd_pend   = mem[bus.mem_addr];
            rd_pend_v = 1'b1;
        end
        if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;
    endtask

    // expected frame result from lane arithmetic on the current memory image
    function automatic void model_frame(input int mode, input logic [7:0] thr,
                                        input logic [63:0] beta, input logic [127:0] cur);
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < 16; i++) begin
                int d, s;
                d = int'(stub_decay(mode, mem[g][8*i +: 8], i, beta[4*i +: 4]));
                s = d + int'(cur[8*i +: 8]);
                if (s > 255) s = 255;
                exp_spk[g][i] = (s >= int'(thr));
                exp_mem[g][8*i +: 8] = exp_spk[g][i] ? 8'd0 : 8'(s);
            end
        end
    endfunction

    task automatic run_frame(input logic [7:0] thr, input logic [63:0] beta,
                             input logic [127:0] cur, input int stall_grp,
                             input int stall_n, input bit mid_change);
        int stalled;
        stalled = 0;
        busy1 = 0; n_done = 0; done_at = -1; n_ev = 0; strobe_bad = 0; beta_seen = '0;
        bus.start = 1'b1; bus.thr_cfg = thr; bus.beta_cfg = beta;
        bus.cur_16n_in = cur; bus.cur_valid = 1'b1;
        for (int c = 1; c <= 4*NG + 1 + stall_n + 4; c++) begin
            tick();
            if (c == 1) busy1 = int'(bus.busy);
            if (bus.done) begin
                if (n_done == 0) begin
                    done_at   = c;
                    beta_seen = bus.load_16n_beta_in;
                end
                n_done++;
            end
            if (bus.spk_valid && n_ev < 8) begin
                ev_spk[n_ev] = bus.spk_out;
                ev_grp[n_ev] = bus.spk_group;
                n_ev++;
            end
            if (bus.cur_ready && (bus.mem_rd_en || bus.mem_wr_en)) strobe_bad++;
            bus.start = mid_change && (c == 3);
            if (mid_change && c >= 3) begin
                bus.thr_cfg  = 8'd0;
                bus.beta_cfg = ~beta;
            end
            if (bus.cur_ready && n_ev == stall_grp && stalled < stall_n) begin
                bus.cur_valid = 1'b0;
                stalled++;
            end else begin
                bus.cur_valid = 1'b1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_model(input string nm, input logic [63:0] beta, input int stall_n);
        chk({nm, "/busy"},    128'(busy1), 128'd1);
        chk({nm, "/ndone"},   128'(n_done), 128'd1);
        chk({nm, "/latency"}, 128'(done_at), 128'(4*NG + 1 + stall_n));
        chk({nm, "/nspk"},    128'(n_ev), 128'(NG));
        chk({nm, "/strobe"},  128'(strobe_bad), 128'd0);
        chk({nm, "/beta"},    128'(beta_seen), 128'(beta));
        for (int g = 0; g < NG; g++) begin
            chk($sformatf("%s/grp%0d", nm, g), 128'(ev_grp[g]), 128'(g));
            chk($sformatf("%s/spk%0d", nm, g), 128'(ev_spk[g]), 128'(exp_spk[g]));
            chk($sformatf("%s/mem%0d", nm, g), mem[g], exp_mem[g]);
        end
    endtask

    initial begin
        vec_t tbl [6];
        logic [63:0]  beta;
        logic [127:0] cur;
        logic [7:0]   thr;
        int           mode;
        bit           hit;
        int           ne;

        tbl[0] = '{0, 8'd100, 8'd20,  8'd255, 16'h0000, {16{8'h46}}};
        tbl[1] = '{1, 8'd100, 8'd100, 8'd255, 16'hFFFF, 128'd0};
        tbl[2] = '{2, 8'd100, 8'd0,   8'd80,  16'hFF00,
                   128'h0000_0000_0000_0000_463C_3228_1E14_0A00};
        tbl[3] = '{0, 8'd100, 8'd20,  8'd0,   16'hFFFF, 128'd0};
        tbl[4] = '{0, 8'd100, 8'd20,  8'd70,  16'hFFFF, 128'd0};
        tbl[5] = '{0, 8'd100, 8'd20,  8'd71,  16'h0000, {16{8'h46}}};

        reset = 1'b1;
        bus.start = 1'b0; bus.beta_cfg = '0; bus.thr_cfg = '0;
        bus.cur_16n_in = '0; bus.cur_valid = 1'b0;
        rd_data = '0; rd_pend = '0; rd_pend_v = 1'b0;
        for (int g = 0; g < NG; g++) mem[g] = '0;

        tick(); tick();
        chk("rst_ctl", 128'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr,
                             bus.cur_ready, bus.spk_valid, bus.spk_group, bus.spk_out}), 128'd0);
        chk("rst_wdata", bus.mem_wr_data, 128'd0);
        chk("rst_regs", bus.load_16n_potential_in | bus.save_16n_potential_in |
                        128'(bus.load_16n_beta_in), 128'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 128'(bus.busy), 128'd0);

        // table-driven frames with spec-derived constants
        beta = 64'h0123_4567_89AB_CDEF;
        for (int t = 0; t < 6; t++) begin
            stub_mode = tbl[t].mode;
            for (int g = 0; g < NG; g++) mem[g] = {16{tbl[t].pre}};
            run_frame(tbl[t].thr, beta, {16{tbl[t].cur}}, -1, 0, 1'b0);
            chk($sformatf("tbl%0d/latency", t), 128'(done_at), 128'd9);
            chk($sformatf("tbl%0d/ndone", t), 128'(n_done), 128'd1);
            chk($sformatf("tbl%0d/nspk", t), 128'(n_ev), 128'(NG));
            for (int g = 0; g < NG; g++) begin
                chk($sformatf("tbl%0d/grp%0d", t, g), 128'(ev_grp[g]), 128'(g));
                chk($sformatf("tbl%0d/spk%0d", t, g), 128'(ev_spk[g]), 128'(tbl[t].exp_spk));
                chk($sformatf("tbl%0d/mem%0d", t, g), mem[g], tbl[t].exp_wr);
            end
            tick();
            chk($sformatf("tbl%0d/hold", t), 128'({bus.spk_out, bus.spk_group}),
                128'({tbl[t].exp_spk, AW'(NG - 1)}));
        end

        // randomized frames against the lane model
        for (int r = 0; r < 8; r++) begin
            mode = int'($urandom_range(0, 3));
            beta = {$urandom, $urandom};
            cur  = {$urandom, $urandom, $urandom, $urandom};
            thr  = 8'($urandom);
            for (int g = 0; g < NG; g++) mem[g] = {$urandom, $urandom, $urandom, $urandom};
            stub_mode = mode;
            model_frame(mode, thr, beta, cur);
            run_frame(thr, beta, cur, -1, 0, 1'b0);
            check_model($sformatf("rnd%0d", r), beta, 0);
        end

        // cur_valid withheld for 5 cycles in group 1
        stub_mode = 0;
        beta = 64'hFEDC_BA98_7654_3210;
        for (int g = 0; g < NG; g++) mem[g] = {16{8'd100}};
        model_frame(0, 8'd255, beta, {16{8'd20}});
        run_frame(8'd255, beta, {16{8'd20}}, 1, 5, 1'b0);
        check_model("stall", beta, 5);

        // config edits and a second start during the frame
        stub_mode = 3;
        beta = {$urandom, $urandom};
        cur  = {$urandom, $urandom, $urandom, $urandom};
        for (int g = 0; g < NG; g++) mem[g] = {$urandom, $urandom, $urandom, $urandom};
        model_frame(3, 8'd50, beta, cur);
        run_frame(8'd50, beta, cur, -1, 0, 1'b1);
        check_model("cfg", beta, 0);

        // reset while group 1 waits in DECAY
        stub_mode = 0;
        mem[0] = {16{8'd100}};
        mem[1] = {16{8'd60}};
        hit = 1'b0; ne = 0;
        bus.thr_cfg = 8'd60; bus.beta_cfg = 64'h1111_2222_3333_4444;
        bus.cur_16n_in = {16{8'd20}}; bus.cur_valid = 1'b1; bus.start = 1'b1;
        for (int c = 0; c < 30 && !hit; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.spk_valid) ne++;
            if (bus.cur_ready && ne == 1 && !bus.cur_valid) hit = 1'b1;
            bus.cur_valid = (ne == 0);
        end
        chk("rstmid/reach", 128'(hit), 128'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstmid/ctl", 128'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr,
                                bus.cur_ready, bus.spk_valid, bus.spk_group, bus.spk_out}), 128'd0);
        chk("rstmid/wdata", bus.mem_wr_data, 128'd0);
        tick(); tick(); tick();
        chk("rstmid/mem1", mem[1], {16{8'd60}});
        chk("rstmid/mem0", mem[0], 128'd0);
        reset = 1'b0;
        tick();
        beta = 64'h5555_AAAA_5555_AAAA;
        model_frame(0, 8'd60, beta, {16{8'd20}});
        run_frame(8'd60, beta, {16{8'd20}}, -1, 0, 1'b0);
        check_model("rerun", beta, 0);

        chk("rw_overlap", 128'(rw_overlap), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_group_sequencer.md
Name: lif_group_sequencer

Overview:
- Frame sequencer sitting directly around u_b_processor; drives its load and save paths.
- Per 16-neuron group: read packed potentials from potential memory, send them through the beta-decay load path, add the incoming synaptic current, threshold to spikes, route through the save path (spike reset), write back.
- Iterates NUM_GROUPS groups per start; emits one 16-bit spike vector per group to the downstream layer logic.

Parameters:
- NUM_GROUPS, 8, neuron groups of 16 per frame (128 neurons); must be >= 1.
- ADDR_W, $clog2(NUM_GROUPS) (min 1), potential memory address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin frame; ignored unless idle
- busy  out  1  high from the cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse at end of frame
- beta_cfg  in  64  16 x 4-bit beta, sampled on accepted start
- thr_cfg  in  8  unsigned spike threshold, sampled on accepted start
- mem_rd_en  out  1  potential memory read strobe
- mem_wr_en  out  1  potential memory write strobe
- mem_addr  out  ADDR_W  group address for read and write
- mem_rd_data  in  128  packed potentials; valid exactly 1 cycle after mem_rd_en
- mem_wr_data  out  128  packed potentials to write
- cur_16n_in  in  128  16 x 8-bit unsigned synaptic current for the current group
- cur_valid  in  1  current valid
- cur_ready  out  1  high only in DECAY
- load_16n_potential_in  out  128  to u_b_processor; equals pot_reg
- load_16n_beta_in  out  64  to u_b_processor; equals beta_reg
- load_16n_potential_out  in  128  decayed potentials from u_b_processor (combinational)
- save_16n_potential_in  out  128  to u_b_processor; equals sum_reg
- save_16n_spk_in  out  16  to u_b_processor; spike vector of sum_reg
- save_16n_potential_out  in  128  spike-reset potentials from u_b_processor
- spk_out  out  16  spike vector for group spk_group
- spk_valid  out  1  one-cycle pulse per group
- spk_group  out  ADDR_W  group index of spk_out

Behaviour:
- Reset (async, high):
  - State IDLE; group counter g=0.
  - pot_reg, sum_reg, beta_reg, thr_reg all 0.
  - All outputs 0: busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, cur_ready, spk_out, spk_valid, spk_group.
- Reset mid-frame: the frame is abandoned with no write issued. Memory contents are whatever earlier FIRE cycles wrote.
- IDLE:
  - start=1 captures beta_cfg into beta_reg and thr_cfg into thr_reg, sets g=0, goes to RD.
- RD: mem_rd_en=1, mem_addr=g. Go to LOAD.
- LOAD: pot_reg <= mem_rd_data. Go to DECAY.
- DECAY:
  - cur_ready=1.
  - Stay while cur_valid=0.
  - On cur_valid=1, per lane i: sum_reg[i] <= min(255, load_16n_potential_out[i] + cur_16n_in[i]), computed as 9-bit unsigned and saturated. Go to FIRE.
- FIRE:
  - spk[i] = (sum_reg[i] >= thr_reg); save_16n_spk_in = spk.
  - mem_wr_en=1, mem_addr=g, mem_wr_data=save_16n_potential_out.
  - spk_valid=1, spk_out=spk, spk_group=g; spk_out and spk_group hold until the next FIRE.
  - If g==NUM_GROUPS-1 go to DONE, else g<=g+1 and go to RD.
- DONE: done=1 for one cycle, then IDLE. busy is low in IDLE only.
- Latency:
  - 4 cycles per group when cur_valid is already high on DECAY entry.
  - Frame = 4*NUM_GROUPS + 1 cycles from the start cycle to the done cycle, exclusive of cur_valid stall.
- thr_reg=0: every lane spikes and every written potential is 0.
- Mid-frame changes to beta_cfg or thr_cfg have no effect until the next start.
- start during busy is ignored; no queuing.
- Read and write never share a cycle.

Decomposition:
- Package lif_pkg:
  - constants NEURONS_PER_GROUP=16, POT_W=8, BETA_W=4;
  - state encoding IDLE/RD/LOAD/DECAY/FIRE/DONE (3-bit localparams).
- One sub-module, sat_add_cmp: per-lane 8-bit saturating add plus >= threshold compare; instantiated 16x via generate.

Test Plan:
- Bench uses a stub for load_16n_potential_out (returns each lane >>1). Memory preset to all lanes 100; cur=20 held valid; thr=255; NUM_GROUPS=2.
  - Required: each group writes 70 (0x46) in all lanes; spk_out=0x0000.
  - done 9 cycles after start.
- Saturation: stub decayed=200, cur=100, thr=255.
  - Required: sum saturates at 255; all lanes spike; spk_out=0xFFFF.
  - With the real save-path stub, written data is 0.
- Mixed lanes: decayed lane i=10*i, cur=0, thr=80.
  - Required: spk_out=0xFF00.
  - Written lanes 0-7 = 10*i; lanes 8-15 = 0.
- Handshake stall: cur_valid held low for 5 cycles in group 1.
  - Required: FSM waits in DECAY with cur_ready=1; no mem strobes during the stall.
  - Frame length grows by exactly 5.
- Reset mid-frame: assert reset during DECAY of group 1.
  - Required: all outputs 0 immediately; no write for group 1; a new start reruns from group 0.
- Config sampling: start with thr=50, change thr_cfg to 0 at cycle 3.
  - Required: spikes use 50 for the whole frame.
  - start asserted while busy is ignored, giving exactly one done pulse.
